// File: rtl/bitonic_merge_sequencer_pkg.sv
// Shared widths and sequencer state type for the bitonic merge datapath.
package bitonic_merge_sequencer_pkg;

    localparam int unsigned NETWORK_WIDTH = 16;
    localparam int unsigned INDEX_WIDTH   = 8;

    typedef enum logic [1:0] {
        LOAD,
        MERGE,
        UNLOAD
    } seq_state_t;

endpackage

// File: rtl/bitonic_merge_sequencer_cx_stage.sv
// One bitonic merge pass: SIZE/2 compare-exchanges whose pairing follows a runtime stride.
module bitonic_cx_stage
    import bitonic_merge_sequencer_pkg::*;
#(
    parameter int unsigned SIZE = 8,
    parameter bit          UP   = 1'b1
) (
    input  logic [NETWORK_WIDTH-1:0] data_i   [SIZE],
    input  logic [INDEX_WIDTH-1:0]   index_i  [SIZE],
    input  logic [$clog2(SIZE)-1:0]  stride_i,
    output logic [NETWORK_WIDTH-1:0] data_o   [SIZE],
    output logic [INDEX_WIDTH-1:0]   index_o  [SIZE]
);

    localparam int unsigned CntW  = $clog2(SIZE);
    localparam int unsigned Pairs = SIZE / 2;

    logic [CntW-1:0]          mask;
    logic [CntW-1:0]          lo_idx       [Pairs];
    logic [CntW-1:0]          hi_idx       [Pairs];
    logic [NETWORK_WIDTH-1:0] first_data   [Pairs];
    logic [INDEX_WIDTH-1:0]   first_index  [Pairs];
    logic [NETWORK_WIDTH-1:0] second_data  [Pairs];
    logic [INDEX_WIDTH-1:0]   second_index [Pairs];

    assign mask = stride_i - 1'b1;

    for (genvar j = 0; j < Pairs; j++) begin : g_pair
        localparam logic [CntW-1:0] PairId = CntW'(j);

        // Lower slot is the pair number with a zero inserted at the stride bit.
        assign lo_idx[j] = ((PairId & ~mask) << 1) | (PairId & mask);
        assign hi_idx[j] = lo_idx[j] | stride_i;

        if (UP) begin : g_up
            comparison_up u_cmp (
                .a_data_i       (data_i[lo_idx[j]]),
                .a_index_i      (index_i[lo_idx[j]]),
                .b_data_i       (data_i[hi_idx[j]]),
                .b_index_i      (index_i[hi_idx[j]]),
                .first_data_o   (first_data[j]),
                .first_index_o  (first_index[j]),
                .second_data_o  (second_data[j]),
                .second_index_o (second_index[j])
            );
        end else begin : g_down
            comparison_down u_cmp (
                .a_data_i       (data_i[lo_idx[j]]),
                .a_index_i      (index_i[lo_idx[j]]),
                .b_data_i       (data_i[hi_idx[j]]),
                .b_index_i      (index_i[hi_idx[j]]),
                .first_data_o   (first_data[j]),
                .first_index_o  (first_index[j]),
                .second_data_o  (second_data[j]),
                .second_index_o (second_index[j])
            );
        end
    end

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            data_o[i]  = data_i[i];
            index_o[i] = index_i[i];
        end
        for (int j = 0; j < Pairs; j++) begin
            data_o[lo_idx[j]]  = first_data[j];
            index_o[lo_idx[j]] = first_index[j];
            data_o[hi_idx[j]]  = second_data[j];
            index_o[hi_idx[j]] = second_index[j];
        end
    end

endmodule

// File: rtl/comparison_down.sv
// Compare-exchange for descending order: the larger key lands in the first slot.
module comparison_down
    import bitonic_merge_sequencer_pkg::*;
(
    input  logic [NETWORK_WIDTH-1:0] a_data_i,
    input  logic [INDEX_WIDTH-1:0]   a_index_i,
    input  logic [NETWORK_WIDTH-1:0] b_data_i,
    input  logic [INDEX_WIDTH-1:0]   b_index_i,
    output logic [NETWORK_WIDTH-1:0] first_data_o,
    output logic [INDEX_WIDTH-1:0]   first_index_o,
    output logic [NETWORK_WIDTH-1:0] second_data_o,
    output logic [INDEX_WIDTH-1:0]   second_index_o
);

    logic swap;

    assign swap           = a_data_i < b_data_i;
    assign first_data_o   = swap ? b_data_i  : a_data_i;
    assign first_index_o  = swap ? b_index_i : a_index_i;
    assign second_data_o  = swap ? a_data_i  : b_data_i;
    assign second_index_o = swap ? a_index_i : b_index_i;

endmodule

// File: rtl/comparison_up.sv
// Compare-exchange for ascending order: the smaller key lands in the first slot.
module comparison_up
    import bitonic_merge_sequencer_pkg::*;
(
    input  logic [NETWORK_WIDTH-1:0] a_data_i,
    input  logic [INDEX_WIDTH-1:0]   a_index_i,
    input  logic [NETWORK_WIDTH-1:0] b_data_i,
    input  logic [INDEX_WIDTH-1:0]   b_index_i,
    output logic [NETWORK_WIDTH-1:0] first_data_o,
    output logic [INDEX_WIDTH-1:0]   first_index_o,
    output logic [NETWORK_WIDTH-1:0] second_data_o,
    output logic [INDEX_WIDTH-1:0]   second_index_o
);

    logic swap;

    // Strict compare so equal keys keep their positions.
    assign swap           = a_data_i > b_data_i;
    assign first_data_o   = swap ? b_data_i  : a_data_i;
    assign first_index_o  = swap ? b_index_i : a_index_i;
    assign second_data_o  = swap ? a_data_i  : b_data_i;
    assign second_index_o = swap ? a_index_i : b_index_i;

endmodule

// File: rtl/bitonic_merge_sequencer.sv
// Serial-in/serial-out bitonic merger: load SIZE pairs, run log2(SIZE) passes on one
// shared comparator stage, then stream the merged pairs out.
module bitonic_merge_sequencer
    import bitonic_merge_sequencer_pkg::*;
#(
    parameter int unsigned SIZE = 8,
    parameter bit          UP   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NETWORK_WIDTH-1:0] in_data,
    input  logic [INDEX_WIDTH-1:0]   in_index,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NETWORK_WIDTH-1:0] out_data,
    output logic [INDEX_WIDTH-1:0]   out_index,
    output logic                     out_last,
    output logic                     busy
);

    localparam int unsigned     CntW     = $clog2(SIZE);
    localparam logic [CntW-1:0] LastSlot = CntW'(SIZE - 1);
    localparam logic [CntW-1:0] LastPass = CntW'(CntW - 1);

    seq_state_t               state_q, state_d;
    logic [CntW-1:0]          load_cnt_q, load_cnt_d;
    logic [CntW-1:0]          pass_cnt_q, pass_cnt_d;
    logic [CntW-1:0]          out_cnt_q, out_cnt_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     busy_q, busy_d;
    logic [NETWORK_WIDTH-1:0] bank_data_q  [SIZE];
    logic [NETWORK_WIDTH-1:0] bank_data_d  [SIZE];
    logic [INDEX_WIDTH-1:0]   bank_index_q [SIZE];
    logic [INDEX_WIDTH-1:0]   bank_index_d [SIZE];
    logic [NETWORK_WIDTH-1:0] cx_data      [SIZE];
    logic [INDEX_WIDTH-1:0]   cx_index     [SIZE];
    logic [CntW-1:0]          stride;

    // Pass 0 uses stride SIZE/2, halving every pass down to 1.
    assign stride = CntW'(SIZE >> (pass_cnt_q + 1'b1));

    bitonic_cx_stage #(
        .SIZE (SIZE),
        .UP   (UP)
    ) u_cx_stage (
        .data_i   (bank_data_q),
        .index_i  (bank_index_q),
        .stride_i (stride),
        .data_o   (cx_data),
        .index_o  (cx_index)
    );

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        out_cnt_d   = out_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        for (int i = 0; i < SIZE; i++) begin
            bank_data_d[i]  = bank_data_q[i];
            bank_index_d[i] = bank_index_q[i];
        end

        unique case (state_q)
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    bank_data_d[load_cnt_q]  = in_data;
                    bank_index_d[load_cnt_q] = in_index;
                    if (load_cnt_q == LastSlot) begin
                        load_cnt_d = '0;
                        state_d    = MERGE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            MERGE: begin
                for (int i = 0; i < SIZE; i++) begin
                    bank_data_d[i]  = cx_data[i];
                    bank_index_d[i] = cx_index[i];
                end
                if (pass_cnt_q == LastPass) begin
                    pass_cnt_d  = '0;
                    state_d     = UNLOAD;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                end else begin
                    pass_cnt_d = pass_cnt_q + 1'b1;
                end
            end
            UNLOAD: begin
                if (out_valid_q && out_ready) begin
                    if (out_cnt_q == LastSlot) begin
                        out_cnt_d   = '0;
                        state_d     = LOAD;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        in_ready_d  = 1'b1;
                    end else begin
                        out_cnt_d  = out_cnt_q + 1'b1;
                        out_last_d = (out_cnt_d == LastSlot);
                    end
                end
            end
            default: begin
                state_d     = LOAD;
                load_cnt_d  = '0;
                pass_cnt_d  = '0;
                out_cnt_d   = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            load_cnt_q  <= '0;
            pass_cnt_q  <= '0;
            out_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                bank_data_q[i]  <= '0;
                bank_index_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            out_cnt_q   <= out_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            for (int i = 0; i < SIZE; i++) begin
                bank_data_q[i]  <= bank_data_d[i];
                bank_index_q[i] <= bank_index_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign out_data  = bank_data_q[out_cnt_q];
    assign out_index = bank_index_q[out_cnt_q];

endmodule

// File: tb/tb_bitonic_merge_sequencer.sv
// Bench: ascending and descending SIZE=8 sequencers fed in lockstep, plus a SIZE=2 instance,
// all checked against a sort-based reference model.
module tb_bitonic_merge_sequencer;
    import bitonic_merge_sequencer_pkg::*;

    localparam int unsigned N = 8;
    typedef logic [NETWORK_WIDTH-1:0] key_t;
    typedef logic [INDEX_WIDTH-1:0]   idx_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid, out_ready;
    key_t in_data;
    idx_t in_index;
    logic a_in_ready, a_out_valid, a_out_last, a_busy;
    logic b_in_ready, b_out_valid, b_out_last, b_busy;
    logic c_in_valid, c_out_ready, c_in_ready, c_out_valid, c_out_last, c_busy;
    key_t a_out_data, b_out_data, c_in_data, c_out_data;
    idx_t a_out_index, b_out_index, c_in_index, c_out_index;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int load_edge [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bitonic_merge_sequencer #(.SIZE(8), .UP(1'b1)) u_dut_up (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_index(in_index), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .out_index(a_out_index),
        .out_last(a_out_last), .busy(a_busy)
    );

    bitonic_merge_sequencer #(.SIZE(8), .UP(1'b0)) u_dut_down (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_index(in_index), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data), .out_index(b_out_index),
        .out_last(b_out_last), .busy(b_busy)
    );

    bitonic_merge_sequencer #(.SIZE(2), .UP(1'b1)) u_dut_pair (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_index(c_in_index), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_index(c_out_index),
        .out_last(c_out_last), .busy(c_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: stable insertion sort by key; the tag follows its key.
    task automatic model_sort(input key_t k[N], input idx_t x[N], input bit up,
                              output key_t ek[N], output idx_t ex[N]);
        key_t tk;
        idx_t tx;
        ek = k;
        ex = x;
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (up ? (ek[j-1] > ek[j]) : (ek[j-1] < ek[j])) begin
                    tk = ek[j-1]; ek[j-1] = ek[j]; ek[j] = tk;
                    tx = ex[j-1]; ex[j-1] = ex[j]; ex[j] = tx;
                end else begin
                    break;
                end
            end
        end
    endtask

    // Distinct keys arranged as an ascending run followed by a descending run.
    task automatic gen_bitonic(output key_t k[N], output idx_t x[N]);
        key_t s[N];
        key_t t;
        key_t front[$];
        key_t back[$];
        int   nf;
        for (int i = 0; i < N; i++) s[i] = key_t'(($urandom_range(0, 8191) << 3) | i);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) front.push_back(s[i]);
            else back.push_front(s[i]);
        end
        nf = front.size();
        for (int i = 0; i < N; i++) begin
            k[i] = (i < nf) ? front[i] : back[i - nf];
            x[i] = idx_t'($urandom_range(0, 255));
        end
    endtask

    task automatic load_ab(input string name, input key_t k[N], input idx_t x[N], input bit bp);
        int i = 0;
        int guard = 0;
        bit hs;
        out_ready = 1'b1;
        while (i < N && guard < 400) begin
            in_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = k[i];
            in_index = x[i];
            @(negedge clk);
            hs = in_valid && a_in_ready;
            @(posedge clk);
            #1;
            if (hs) i++;
            guard++;
        end
        in_valid = 1'b0;
        check_eq({name, " pairs loaded"}, 32'(i), N);
    endtask

    task automatic unload_ab(input string name, input key_t uk[N], input idx_t ux[N],
                             input key_t dk[N], input idx_t dx[N], input bit bp);
        int   lat = 0;
        int   got = 0;
        int   guard = 0;
        bit   stalled = 1'b0;
        key_t held_a, held_b;
        idx_t held_ax, held_bx;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check_eq({name, " busy in merge"}, 32'(a_busy), 1);
                check_eq({name, " in_ready in merge"}, 32'(a_in_ready), 0);
            end
        end while (!a_out_valid && lat < 50);
        check_eq({name, " latency edges"}, 32'(lat - 1), 3);
        check_eq({name, " down out_valid"}, 32'(b_out_valid), 1);
        while (got < N && guard < 400) begin
            if (stalled) begin
                check_eq({name, " held data"}, 32'(a_out_data), 32'(held_a));
                check_eq({name, " held index"}, 32'(a_out_index), 32'(held_ax));
                check_eq({name, " held down data"}, 32'(b_out_data), 32'(held_b));
                check_eq({name, " held down index"}, 32'(b_out_index), 32'(held_bx));
            end
            check_eq({name, " in_ready in unload"}, 32'(a_in_ready), 0);
            if (a_out_valid && out_ready) begin
                check_eq({name, " up data"}, 32'(a_out_data), 32'(uk[got]));
                check_eq({name, " up index"}, 32'(a_out_index), 32'(ux[got]));
                check_eq({name, " up last"}, 32'(a_out_last), 32'(got == N - 1));
                check_eq({name, " down data"}, 32'(b_out_data), 32'(dk[got]));
                check_eq({name, " down index"}, 32'(b_out_index), 32'(dx[got]));
                check_eq({name, " down last"}, 32'(b_out_last), 32'(got == N - 1));
                got++;
                stalled = 1'b0;
            end else if (a_out_valid) begin
                stalled = 1'b1;
                held_a  = a_out_data;
                held_ax = a_out_index;
                held_b  = b_out_data;
                held_bx = b_out_index;
            end
            @(posedge clk);
            #1;
            if (bp) out_ready = ~out_ready;
            @(negedge clk);
            guard++;
        end
        check_eq({name, " pairs unloaded"}, 32'(got), N);
        check_eq({name, " back to load"}, {29'd0, a_in_ready, a_out_valid, a_busy}, 32'h4);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_ab(input string name, input key_t k[N], input idx_t x[N], input bit bp);
        key_t uk[N], dk[N];
        idx_t ux[N], dx[N];
        model_sort(k, x, 1'b1, uk, ux);
        model_sort(k, x, 1'b0, dk, dx);
        load_ab(name, k, x, bp);
        unload_ab(name, uk, ux, dk, dx, bp);
    endtask

    task automatic reset_mid_merge(input key_t k[N], input idx_t x[N]);
        int seen = 0;
        load_ab("abort", k, x, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort busy", 32'(a_busy), 0);
        check_eq("abort in_ready", 32'(a_in_ready), 1);
        check_eq("abort out_valid", 32'(a_out_valid), 0);
        check_eq("abort down busy", 32'(b_busy), 0);
        #2;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            seen += int'(a_out_valid) + int'(b_out_valid);
        end
        check_eq("abort no stale output", 32'(seen), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_pairs();
        key_t pk[N], ek[N];
        idx_t px[N], ex[N];
        int   r;
        pk[0] = 16'd9;
        pk[1] = 16'd4;
        for (int b = 1; b < 4; b++) begin
            r = int'($urandom_range(0, 65535));
            pk[2*b]   = key_t'(r);
            pk[2*b+1] = key_t'(r + 1 + int'($urandom_range(0, 100)));
        end
        for (int i = 0; i < N; i++) px[i] = idx_t'(i + 16);
        for (int b = 0; b < 4; b++) begin
            if (pk[2*b] > pk[2*b+1]) begin
                ek[2*b] = pk[2*b+1]; ex[2*b] = px[2*b+1];
                ek[2*b+1] = pk[2*b]; ex[2*b+1] = px[2*b];
            end else begin
                ek[2*b] = pk[2*b]; ex[2*b] = px[2*b];
                ek[2*b+1] = pk[2*b+1]; ex[2*b+1] = px[2*b+1];
            end
        end
        fork
            begin : producer
                int  i = 0;
                int  guard = 0;
                bit  hs;
                while (i < N && guard < 200) begin
                    c_in_valid = 1'b1;
                    c_in_data  = pk[i];
                    c_in_index = px[i];
                    @(negedge clk);
                    hs = c_in_valid && c_in_ready;
                    @(posedge clk);
                    #1;
                    if (hs) begin
                        if (i % 2 == 1) load_edge[i/2] = cyc;
                        i++;
                    end
                    guard++;
                end
                c_in_valid = 1'b0;
                check_eq("pair pairs loaded", 32'(i), N);
            end
            begin : consumer
                int got = 0;
                int guard = 0;
                bit chk_ready = 1'b0;
                while (got < N && guard < 200) begin
                    @(negedge clk);
                    guard++;
                    if (chk_ready) begin
                        check_eq("pair in_ready after block", 32'(c_in_ready), 1);
                        chk_ready = 1'b0;
                    end
                    if (c_out_valid) begin
                        if (got % 2 == 0) check_eq("pair latency edges", 32'(cyc - load_edge[got/2]), 1);
                        check_eq("pair data", 32'(c_out_data), 32'(ek[got]));
                        check_eq("pair index", 32'(c_out_index), 32'(ex[got]));
                        check_eq("pair last", 32'(c_out_last), 32'(got % 2 == 1));
                        if (got % 2 == 1) chk_ready = 1'b1;
                        got++;
                    end
                end
                @(negedge clk);
                check_eq("pair in_ready after final block", 32'(c_in_ready), 1);
                check_eq("pair pairs unloaded", 32'(got), N);
            end
        join
    endtask

    initial begin
        key_t k[N];
        idx_t x[N];
        in_valid    = 1'b0;
        in_data     = '0;
        in_index    = '0;
        out_ready   = 1'b1;
        c_in_valid  = 1'b0;
        c_in_data   = '0;
        c_in_index  = '0;
        c_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset in_ready", 32'(a_in_ready), 1);
        check_eq("reset out_valid", 32'(a_out_valid), 0);
        check_eq("reset out_last", 32'(a_out_last), 0);
        check_eq("reset busy", 32'(a_busy), 0);
        check_eq("reset out_data", 32'(a_out_data), 0);
        check_eq("reset out_index", 32'(a_out_index), 0);
        check_eq("reset down in_ready", 32'(b_in_ready), 1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        k = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd6, 16'd4, 16'd2, 16'd0};
        x = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        run_ab("sort", k, x, 1'b0);
        run_ab("backpressure", k, x, 1'b1);
        reset_mid_merge(k, x);
        gen_bitonic(k, x);
        run_ab("fresh after abort", k, x, 1'b0);
        k = '{default: 16'd2};
        x = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        run_ab("ties", k, x, 1'b0);
        for (int r = 0; r < 6; r++) begin
            gen_bitonic(k, x);
            run_ab("random", k, x, (r % 2) == 1);
        end
        run_pairs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

endmodule
